// File: rtl/if_id_queue_if.sv
// IF/ID queue handshake bundle: enqueue side from fetch,
// dequeue side to decode with predecode flags and occupancy.
interface if_id_queue_if #(
    parameter int DEPTH = 4
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              in_valid;
    logic [63:0]       in_pc;
    logic [31:0]       in_instr;
    logic              in_ready;

    logic              out_valid;
    logic [63:0]       out_pc;
    logic [31:0]       out_instr;
    logic              out_is_branch;
    logic              out_is_jump;
    logic              out_ready;

    logic [ADDR_W:0]   count;

    modport master (
        output in_valid,
        output in_pc,
        output in_instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_pc,
        input  out_instr,
        input  out_is_branch,
        input  out_is_jump,
        input  count
    );

    modport slave (
        input  in_valid,
        input  in_pc,
        input  in_instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_pc,
        output out_instr,
        output out_is_branch,
        output out_is_jump,
        output count
    );
endinterface

// File: rtl/if_id_queue.sv
// Decoupling instruction queue between fetch and decode.
// Circular buffer of {pc, instr}, flushed on redirect, with opcode predecode.
module if_id_queue #(
    parameter int          DEPTH  = 4,
    parameter logic [63:0] RST_PC = 64'h0000_0000_8000_0000
) (
    input logic         clk,
    input logic         rst,
    input logic         flush,
    if_id_queue_if.slave q
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  cnt;

    logic   in_ready;
    logic   out_valid;
    logic   enq;
    logic   deq;
    entry_t head;
    logic   is_branch;
    logic   is_jump;

    // Ready comes only from the registered count, never from out_ready.
    assign in_ready  = (cnt != FULL);
    assign out_valid = (cnt != '0);
    assign enq       = q.in_valid & in_ready;
    assign deq       = out_valid & q.out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; a flushed enqueue never lands.
    always_ff @(posedge clk) begin
        if (rst && !flush && enq) begin
            mem[wr_ptr] <= '{pc: q.in_pc, instr: q.in_instr};
        end
    end

    always_comb begin
        head = '{pc: RST_PC, instr: 32'h0};
        if (out_valid) head = mem[rd_ptr];
    end

    always_comb begin
        is_branch = 1'b0;
        is_jump   = 1'b0;
        unique case (1'b1)
            head.instr[6:0] == OP_BRANCH: is_branch = out_valid;
            head.instr[6:0] == OP_JAL:    is_jump   = out_valid;
            head.instr[6:0] == OP_JALR:   is_jump   = out_valid;
            default: ;
        endcase
    end

    assign q.in_ready      = in_ready;
    assign q.out_valid     = out_valid;
    assign q.out_pc        = head.pc;
    assign q.out_instr     = head.instr;
    assign q.out_is_branch = is_branch;
    assign q.out_is_jump   = is_jump;
    assign q.count         = cnt;
endmodule

// File: tb/tb_if_id_queue.sv
// Randomized and directed bench for if_id_queue
// against a queue-based occupancy/order reference.
module tb_if_id_queue;
    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    if_id_queue_if #(.DEPTH(DEPTH)) bus ();

    if_id_queue #(
        .DEPTH (DEPTH),
        .RST_PC(RST_PC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .q    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [95:0] mq[$];

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int          n;
        bit          v;
        logic [63:0] epc;
        logic [31:0] ei;
        n   = mq.size();
        v   = (n > 0);
        epc = v ? mq[0][95:32] : RST_PC;
        ei  = v ? mq[0][31:0] : 32'h0;
        chk("out_valid", bus.out_valid, v);
        chk("in_ready", bus.in_ready, n < DEPTH);
        chk("count", bus.count, n);
        chk("out_pc", bus.out_pc, epc);
        chk("out_instr", bus.out_instr, ei);
        chk("is_branch", bus.out_is_branch,
            v && ei[6:0] == 7'h63);
        chk("is_jump", bus.out_is_jump,
            v && (ei[6:0] == 7'h6F || ei[6:0] == 7'h67));
    endtask

    task automatic model_update();
        bit acc;
        bit pop;
        acc = bus.in_valid && (mq.size() < DEPTH);
        pop = bus.out_ready && (mq.size() > 0);
        if (!rst || flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back({bus.in_pc, bus.in_instr});
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit v, input logic [63:0] pc,
                         input logic [31:0] ins, input bit ordy);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
    endtask

    logic [31:0] t5_ins [4];
    bit          t5_br  [4];
    bit          t5_jmp [4];

    initial begin
        int          k;
        bit          acc;
        logic [63:0] pc;
        logic [31:0] ins;

        // T1: reset held two cycles with in_valid high
        drive(1'b1, 64'h8000_0000, 32'h13, 1'b0);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            model_update();
            #1;
        end
        rst = 1'b1;
        drive(1'b0, 64'h0, 32'h0, 1'b0);
        chk("t1_count", bus.count, 0);
        chk("t1_valid", bus.out_valid, 0);
        chk("t1_pc", bus.out_pc, RST_PC);
        chk("t1_ready", bus.in_ready, 1);
        cycle();

        // T2: fill to full, fifth request held
        k = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 64'h8000_0000 + 64'(4 * k), 32'h13, 1'b0);
            acc = (mq.size() < DEPTH);
            cycle();
            if (acc) k++;
        end
        chk("t2_count", bus.count, 4);
        chk("t2_ready", bus.in_ready, 0);
        chk("t2_pc", bus.out_pc, 64'h8000_0000);
        chk("t2_held", k, 4);
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("t2_drain", bus.count, 0);

        // T3: streaming, occupancy steady at one
        for (int i = 0; i < 20; i++) begin
            pc = 64'h8000_1000 + 64'(4 * i);
            drive(1'b1, pc, 32'h13, 1'b1);
            cycle();
            chk("t3_count", bus.count, 1);
            chk("t3_pc", bus.out_pc, pc);
        end
        bus.in_valid = 1'b0;
        cycle();

        // T4: flush with a concurrent enqueue
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h8000_0200 + 64'(4 * i), 32'h13, 1'b0);
            cycle();
        end
        chk("t4_pre", bus.count, 3);
        drive(1'b1, 64'h8000_0100, 32'h13, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("t4_count", bus.count, 0);
        chk("t4_valid", bus.out_valid, 0);
        drive(1'b0, 64'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_gone", bus.out_valid, 0);
        end

        // T5: predecode flags
        t5_ins = '{32'h0000_0063, 32'h0000_006F,
                   32'h0000_8067, 32'h0000_0013};
        t5_br  = '{1'b1, 1'b0, 1'b0, 1'b0};
        t5_jmp = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h8000_0300 + 64'(4 * i), t5_ins[i], 1'b0);
            cycle();
        end
        drive(1'b0, 64'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t5_instr", bus.out_instr, t5_ins[i]);
            chk("t5_br", bus.out_is_branch, t5_br[i]);
            chk("t5_jmp", bus.out_is_jump, t5_jmp[i]);
            cycle();
        end
        chk("t5_empty", bus.count, 0);

        // T6: random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            pc = {$urandom(), $urandom()};
            ins = $urandom();
            case ($urandom_range(0, 3))
                0: ins[6:0] = 7'h63;
                1: ins[6:0] = 7'h6F;
                2: ins[6:0] = 7'h67;
                default: ;
            endcase
            drive($urandom_range(0, 3) != 0, pc, ins,
                  $urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 63) != 0);
            cycle();
        end
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 64'h0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) cycle();
        chk("t6_final", bus.count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
